// File: rtl/rram_fifo_sf.sv
// Synchronous show-ahead FIFO for the RRAM controller queues: active-low push/pop
// strobes, registered occupancy flags, sticky overflow/underflow error.
module rram_fifo_sf #(
    parameter int WIDTH    = 20,
    parameter int DEPTH    = 8,
    parameter int AE_LEVEL = 1,
    parameter int AF_LEVEL = 1,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             push_n,
    input  logic [WIDTH-1:0] din,
    input  logic             pop_n,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             almost_empty,
    output logic             full,
    output logic             almost_full,
    output logic             error,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_empty;
    logic             r_almost_empty;
    logic             r_full;
    logic             r_almost_full;
    logic             r_error;

    logic             w_pop_ok;
    logic             w_push_ok;
    logic             w_err_evt;
    logic [CW-1:0]    w_count_nxt;
    logic [PW-1:0]    w_wr_ptr_nxt;
    logic [PW-1:0]    w_rd_ptr_nxt;
    logic             w_empty_nxt;
    logic             w_full_nxt;
    logic             w_almost_empty_nxt;
    logic             w_almost_full_nxt;

    // Accept/reject decisions, next occupancy, pointer wrap and next-state flags.
    always_comb begin
        w_pop_ok           = 1'b0;
        w_push_ok          = 1'b0;
        w_err_evt          = 1'b0;
        w_count_nxt        = r_count;
        w_wr_ptr_nxt       = r_wr_ptr;
        w_rd_ptr_nxt       = r_rd_ptr;
        w_empty_nxt        = 1'b1;
        w_full_nxt         = 1'b0;
        w_almost_empty_nxt = 1'b1;
        w_almost_full_nxt  = 1'b0;

        w_pop_ok  = ~pop_n & (r_count != {CW{1'b0}});
        // A pop in the same cycle frees the slot a push into a full FIFO needs.
        w_push_ok = ~push_n & ((r_count != CW'(DEPTH)) | w_pop_ok);
        w_err_evt = (~pop_n & ~w_pop_ok) | (~push_n & ~w_push_ok);

        case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase

        if (w_push_ok) begin
            w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? {PW{1'b0}} : r_wr_ptr + PW'(1);
        end else begin
            w_wr_ptr_nxt = r_wr_ptr;
        end

        if (w_pop_ok) begin
            w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? {PW{1'b0}} : r_rd_ptr + PW'(1);
        end else begin
            w_rd_ptr_nxt = r_rd_ptr;
        end

        w_empty_nxt        = (w_count_nxt == {CW{1'b0}});
        w_full_nxt         = (w_count_nxt == CW'(DEPTH));
        w_almost_empty_nxt = (int'(w_count_nxt) <= AE_LEVEL);
        w_almost_full_nxt  = (int'(w_count_nxt) >= (DEPTH - AF_LEVEL));
    end

    // Control state and registered flags; reset overrides any strobe.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_wr_ptr       <= {PW{1'b0}};
            r_rd_ptr       <= {PW{1'b0}};
            r_count        <= {CW{1'b0}};
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_full         <= 1'b0;
            r_almost_full  <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_count        <= w_count_nxt;
            r_empty        <= w_empty_nxt;
            r_almost_empty <= w_almost_empty_nxt;
            r_full         <= w_full_nxt;
            r_almost_full  <= w_almost_full_nxt;
            r_error        <= r_error | w_err_evt;
        end
    end

    // Storage write; contents survive reset, only pointers are cleared.
    always_ff @(posedge CLK) begin
        if (!reset && w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    assign dout         = r_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];
    assign empty        = r_empty;
    assign almost_empty = r_almost_empty;
    assign full         = r_full;
    assign almost_full  = r_almost_full;
    assign error        = r_error;
    assign count        = r_count;

endmodule

// File: doc/rram_fifo_sf.md
# rram_fifo_sf

Synchronous show-ahead FIFO serving the producer/consumer ends of the RRAM controller's instruction, input-data and output-data queues. The host side writes with an active-low push strobe; the controller side reads with an active-low pop strobe and sees the head word on `dout` without a read latency. Registered flags drive the controller's `empty_*` / `full_*` inputs directly. One instance is used per queue, sized by parameters.

## Interface
- `WIDTH`, 20: word width. Use 20 for instructions (INSTR_WIDTH+OPCODE_WIDTH), 64 for data.
- `DEPTH`, 8: number of entries, ≥2. Need not be a power of two.
- `AE_LEVEL`, 1: `almost_empty` asserts when count ≤ AE_LEVEL.
- `AF_LEVEL`, 1: `almost_full` asserts when count ≥ DEPTH−AF_LEVEL.
- `CLK`  in  1: single clock, all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `push_n`  in  1: active-low write strobe, sampled at rising edge.
- `din`  in  WIDTH: write data, captured when the push is accepted.
- `pop_n`  in  1: active-low read strobe; consumes the current head word.
- `dout`  out  WIDTH: head word (show-ahead); all zeros when `empty`=1.
- `empty`  out  1: count == 0.
- `almost_empty`  out  1: see AE_LEVEL.
- `full`  out  1: count == DEPTH.
- `almost_full`  out  1: see AF_LEVEL.
- `error`  out  1: sticky overflow/underflow flag.
- `count`  out  $clog2(DEPTH+1): occupancy.

## Operation
- **Storage and pointers.** Storage is DEPTH×WIDTH registers with write pointer `wr_ptr`, read pointer `rd_ptr` and occupancy counter `count`.
  - Each pointer increments by 1 per accepted operation.
  - A pointer at DEPTH−1 wraps to 0 by explicit compare (no power-of-two masking).
- **Accepted push** (push_n=0 and (count<DEPTH or pop accepted in the same cycle)):
  - mem[wr_ptr] ← din.
  - wr_ptr advances.
- **Accepted pop** (pop_n=0 and count>0): rd_ptr advances.
- **Count update** per cycle: +1 (push only), −1 (pop only), unchanged (both or neither).
- **Push while full, no pop:** word dropped, state unchanged, `error`←1.
- **Pop while empty:** pop ignored, `error`←1.
  - A simultaneous push is still accepted, so count becomes 1.
- **Push+pop while full:** both accepted, count stays DEPTH, no error.
- **Push+pop with 0<count<DEPTH:** both accepted, no error.
  - When count=1, dout shows the newly pushed word next cycle.
- **Error flag:** `error` is cleared only by reset.
- **Flags:** `empty`, `full`, `almost_*` are registered, computed from next-state count, so they are coherent with `count` every cycle.
- **dout:** combinational from mem[rd_ptr] gated by `empty`.
- **Reset:**
  - Values: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, error=0, dout=0.
  - Memory contents are not cleared.
  - Reset overrides any simultaneous push/pop.

## Timing
- **Push at edge N:**
  - count, flags and dout (if the FIFO was empty) update immediately after edge N.
  - Latency is 1 cycle from strobe to visibility.
- **Pop at edge N:** the next word appears on dout immediately after edge N. Sustained pop_n=0 therefore drains one word per cycle.
- **Controller interface:**
  - The controller may hold pop_n low continuously while empty=0.
  - Over-pop beyond empty is flagged, not stalled.
- **Full→not-full** is visible the cycle after the pop; the host must sample `full` before asserting push_n.
- **Reset mid-burst:** outputs take reset values after the reset edge. The first push after reset deasserts is accepted normally.

## Test plan
1. **Reset and first word.** Reset for 2 cycles, then push 20'h6_1000 once.
   - Before the push: empty=1, dout=0, count=0.
   - Next cycle: empty=0, dout=20'h6_1000, count=1, almost_empty=1.
2. **Fill, overflow, wrap.** DEPTH=8; push 8 words 20'h0_0001..20'h0_0008, then push 20'h0_0009.
   - After 8 pushes: full=1, almost_full=1 at count=7, count=8.
   - The 9th push is dropped and error=1.
   - Popping 8 times reads 1..8 in order; then empty=1.
   - Push 20'h0_000A afterwards: it wraps correctly and dout=20'h0_000A.
3. **Simultaneous push+pop when full.** Fill with 1..8, then push 9 with pop in one cycle.
   - count stays 8, dout=2, error=0.
   - Draining reads 2..9.
4. **Simultaneous push+pop when empty.** Apply both with din=64'hABCD_ABCD_ABCD_ABCD (WIDTH=64).
   - error=1, count=1, dout=64'hABCD_ABCD_ABCD_ABCD.
5. **Streaming and non-power-of-two depth.** DEPTH=6; hold push_n and pop_n low together for 20 cycles after 3 prefill words.
   - count stays 3 throughout.
   - Output sequence equals input sequence delayed by 3 words.
   - No error.
6. **Reset mid-operation.** With count=5, assert reset during a push.
   - Next cycle: count=0, empty=1, error=0, dout=0.
   - The pushed word is not stored.
